// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types, PID constants and helpers for the USB TX packet controller
package usb_tx_pkg;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4,
        TX_STALL = 3'd5,
        TX_RSVD6 = 3'd6,
        TX_RSVD7 = 3'd7
    } tx_packet_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEGIN = 3'd1,
        S_PID   = 3'd2,
        S_DATA  = 3'd3,
        S_EOP   = 3'd4
    } state_t;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // The PID goes on the wire with its one's complement in the upper nibble as a check field.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

    // Illegal and idle codes map to 0; they never reach the latch.
    function automatic logic [3:0] code_to_pid(input tx_packet_t code);
        case (code)
            TX_DATA0: return PID_DATA0;
            TX_DATA1: return PID_DATA1;
            TX_ACK:   return PID_ACK;
            TX_NAK:   return PID_NAK;
            TX_STALL: return PID_STALL;
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/tx_timeout_counter.sv
// rtl/tx_timeout_counter.sv - per-byte watchdog for the TX packet controller
module tx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    // expired fires on the edge where the count would step onto TIMEOUT_CYCLES-1,
    // so the error pulse lands TIMEOUT_CYCLES cycles after the BEGIN cycle.
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 2);

    logic [W-1:0] count;

    // Count idle waiting cycles; any encoder activity or leaving the wait states restarts it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/tx_packet_ctrl.sv
// rtl/tx_packet_ctrl.sv - USB TX packet sequencer: PID, data-byte fetch, EOP, size and watchdog checks
module tx_packet_ctrl
    import usb_tx_pkg::*;
#(
    parameter int MAX_BYTES      = 64,
    parameter int CNT_W          = $clog2(MAX_BYTES + 1),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       tx_packet,
    input  logic [CNT_W-1:0] buffer_occupancy,
    input  logic             byte_done,
    input  logic             end_packet,
    output logic             tx_transfer_active,
    output logic             begin_packet,
    output logic [7:0]       pid_out,
    output logic             get_tx_packet_data,
    output logic [CNT_W-1:0] bytes_sent,
    output logic             tx_error
);

    state_t           state;
    logic [3:0]       pid_reg;
    logic [CNT_W-1:0] rem;

    tx_packet_t req;
    logic       req_data;
    logic       req_illegal;
    logic       req_oversize;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;

    assign req          = tx_packet_t'(tx_packet);
    assign req_data     = (req == TX_DATA0) || (req == TX_DATA1);
    assign req_illegal  = (req == TX_RSVD6) || (req == TX_RSVD7);
    assign req_oversize = req_data && (buffer_occupancy > CNT_W'(MAX_BYTES));

    // Watchdog is held clear in IDLE and BEGIN so it always starts from zero on the PID state.
    assign wd_clear  = byte_done || end_packet || (state == S_IDLE) || (state == S_BEGIN);
    assign wd_enable = (state == S_PID) || (state == S_DATA) || (state == S_EOP);

    tx_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign tx_transfer_active = (state != S_IDLE);
    assign begin_packet       = (state == S_BEGIN);
    assign pid_out            = tx_transfer_active ? pid_byte(pid_reg) : 8'h00;

    // Packet sequencer; pops and errors are registered one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            pid_reg            <= 4'b0000;
            rem                <= '0;
            bytes_sent         <= '0;
            get_tx_packet_data <= 1'b0;
            tx_error           <= 1'b0;
        end else begin
            get_tx_packet_data <= 1'b0;
            tx_error           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_illegal || req_oversize) begin
                        tx_error <= 1'b1;
                    end else if (req != TX_NONE) begin
                        pid_reg    <= code_to_pid(req);
                        rem        <= req_data ? buffer_occupancy : '0;
                        bytes_sent <= '0;
                        state      <= S_BEGIN;
                    end
                end
                S_BEGIN: begin
                    state <= S_PID;
                end
                S_PID, S_DATA: begin
                    // An early EOP from the encoder wins over a coincident byte_done.
                    if (end_packet) begin
                        tx_error <= 1'b1;
                        state    <= S_IDLE;
                    end else if (byte_done) begin
                        if (rem != '0) begin
                            get_tx_packet_data <= 1'b1;
                            rem                <= rem - CNT_W'(1);
                            bytes_sent         <= bytes_sent + CNT_W'(1);
                            state              <= S_DATA;
                        end else begin
                            state <= S_EOP;
                        end
                    end else if (wd_expired) begin
                        tx_error <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_EOP: begin
                    if (end_packet) begin
                        state <= S_IDLE;
                    end else if (wd_expired) begin
                        tx_error <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_packet_ctrl.sv
// tb/tb_tx_packet_ctrl.sv - scoreboard bench for tx_packet_ctrl
module tb_tx_packet_ctrl;

    localparam int MAX_BYTES      = 8;
    localparam int CNT_W          = $clog2(MAX_BYTES + 1);
    localparam int TIMEOUT_CYCLES = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       tx_packet = 3'd0;
    logic [CNT_W-1:0] buffer_occupancy = '0;
    logic             byte_done = 1'b0;
    logic             end_packet = 1'b0;
    logic             tx_transfer_active;
    logic             begin_packet;
    logic [7:0]       pid_out;
    logic             get_tx_packet_data;
    logic [CNT_W-1:0] bytes_sent;
    logic             tx_error;

    tx_packet_ctrl #(
        .MAX_BYTES      (MAX_BYTES),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .byte_done          (byte_done),
        .end_packet         (end_packet),
        .tx_transfer_active (tx_transfer_active),
        .begin_packet       (begin_packet),
        .pid_out            (pid_out),
        .get_tx_packet_data (get_tx_packet_data),
        .bytes_sent         (bytes_sent),
        .tx_error           (tx_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit err;
        int bytes;
        int pops;
    } exp_t;

    logic [7:0] pid_q[$];
    exp_t       end_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int begin_cyc = 0;
    int err_cyc = 0;
    bit prev_active = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic end_event(input bit err);
        exp_t e;
        chk("end_expected", 32'(end_q.size() != 0), 32'd1);
        if (end_q.size() != 0) begin
            e = end_q.pop_front();
            chk("end_kind", 32'(err), 32'(e.err));
            chk("bytes_sent", 32'(bytes_sent), 32'(e.bytes));
            chk("pop_count", 32'(pop_cnt), 32'(e.pops));
        end
        pop_cnt = 0;
    endtask

    // Output monitor: pops the scoreboard on packet start and packet end/error.
    always @(negedge clk) begin
        if (rst) begin
            prev_active = 1'b0;
            pop_cnt     = 0;
        end else begin
            if (begin_packet) begin
                begin_cyc = cyc;
                pop_cnt   = 0;
                chk("begin_expected", 32'(pid_q.size() != 0), 32'd1);
                if (pid_q.size() != 0) chk("pid_out", 32'(pid_out), 32'(pid_q.pop_front()));
            end
            if (get_tx_packet_data) pop_cnt = pop_cnt + 1;
            if (tx_error) begin
                err_cyc = cyc;
                chk("err_in_idle", 32'(tx_transfer_active), 32'd0);
                end_event(1'b1);
            end else if (prev_active && !tx_transfer_active) begin
                end_event(1'b0);
            end
            prev_active = tx_transfer_active;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pid(input logic [7:0] p);
        pid_q.push_back(p);
    endtask

    task automatic push_end(input bit err, input int bytes, input int pops);
        exp_t e;
        e.err   = err;
        e.bytes = bytes;
        e.pops  = pops;
        end_q.push_back(e);
    endtask

    task automatic request(input int code, input int occ);
        tx_packet        = 3'(code);
        buffer_occupancy = CNT_W'(occ);
        tick(1);
        tx_packet = 3'd0;
    endtask

    task automatic pulse_byte(input bit with_end);
        byte_done  = 1'b1;
        end_packet = with_end;
        tick(1);
        byte_done  = 1'b0;
        end_packet = 1'b0;
        tick(1);
    endtask

    task automatic pulse_end();
        end_packet = 1'b1;
        tick(1);
        end_packet = 1'b0;
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_active"}, 32'(tx_transfer_active), 32'd0);
        chk({tag, "_begin"}, 32'(begin_packet), 32'd0);
        chk({tag, "_pid"}, 32'(pid_out), 32'd0);
        chk({tag, "_get"}, 32'(get_tx_packet_data), 32'd0);
        chk({tag, "_bytes"}, 32'(bytes_sent), 32'd0);
        chk({tag, "_err"}, 32'(tx_error), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // ACK: handshake, no data pops
        push_pid(8'hD2);
        push_end(1'b0, 0, 0);
        request(3, 0);
        chk("begin_latency", 32'(begin_packet), 32'd1);
        tick(1);
        pulse_byte(1'b0);
        tick(2);
        pulse_end();

        // DATA0 with 4 bytes
        push_pid(8'hC3);
        push_end(1'b0, 4, 4);
        request(1, 4);
        tick(1);
        repeat (5) pulse_byte(1'b0);
        tick(1);
        pulse_end();

        // DATA0 at exactly MAX_BYTES
        push_pid(8'hC3);
        push_end(1'b0, MAX_BYTES, MAX_BYTES);
        request(1, MAX_BYTES);
        tick(1);
        repeat (MAX_BYTES + 1) pulse_byte(1'b0);
        pulse_end();

        // Oversize DATA1 and illegal codes: error, no begin, bytes_sent held
        push_end(1'b1, MAX_BYTES, 0);
        request(2, MAX_BYTES + 1);
        tick(2);
        push_end(1'b1, MAX_BYTES, 0);
        request(7, 0);
        tick(2);
        push_end(1'b1, MAX_BYTES, 0);
        request(6, 0);
        tick(2);

        // DATA1 3 bytes, end_packet coincident with 2nd byte_done
        push_pid(8'h4B);
        push_end(1'b1, 1, 1);
        request(2, 3);
        tick(1);
        pulse_byte(1'b0);
        pulse_byte(1'b1);
        tick(2);

        // DATA0 2 bytes, byte_done withheld: watchdog error
        push_pid(8'hC3);
        push_end(1'b1, 0, 0);
        err_cyc = 0;
        request(1, 2);
        tick(TIMEOUT_CYCLES + 4);
        chk("timeout_latency", 32'(err_cyc - begin_cyc), 32'(TIMEOUT_CYCLES));

        // ACK after the watchdog error
        push_pid(8'hD2);
        push_end(1'b0, 0, 0);
        request(3, 0);
        tick(1);
        pulse_byte(1'b0);
        pulse_end();

        // Reset mid DATA packet
        push_pid(8'hC3);
        request(1, 3);
        tick(1);
        pulse_byte(1'b0);
        rst = 1'b1;
        pid_q.delete();
        end_q.delete();
        tick(1);
        check_all_zero("midrst");
        rst = 1'b0;
        tick(1);

        // New DATA0 after reset
        push_pid(8'hC3);
        push_end(1'b0, 2, 2);
        request(1, 2);
        tick(1);
        repeat (3) pulse_byte(1'b0);
        pulse_end();

        tick(3);
        chk("pid_q_drained", 32'(pid_q.size()), 32'd0);
        chk("end_q_drained", 32'(end_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
